instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//   Instruction fetch/issue sequencer for the GPP16 core; it produces the opcode stream the decoder consumes.
//   Walks a PC through a synchronous instruction memory (1-cycle read latency).
//   Presents each 16-bit instruction, with its 5-bit opcode field, to decode/execute over a valid/ready handshake.
//   Stops permanently after issuing HLT (opcode 5'd31); leaves that state only by reset.
// PARAMETERS
//   ADDR_W    8    instruction memory address / PC width
//   INSTR_W   16   instruction width; opcode = instr[INSTR_W-1 -: 5]
//   RESET_PC  0    PC value loaded on reset
// PORTS
//   clk          in   1        clock; all state updates on rising edge
//   rst          in   1        synchronous, active-high reset
//   start        in   1        1-cycle pulse: begin fetching at current PC (honoured only in IDLE)
//   imem_en      out  1        instruction memory read strobe
//   imem_addr    out  ADDR_W   read address (= PC)
//   imem_rdata   in   INSTR_W  read data, valid the cycle after imem_en=1
//   instr_valid  out  1        instr/opcode/instr_pc hold a valid instruction
//   instr_ready  in   1        downstream accepts instruction this cycle
//   instr        out  INSTR_W  issued instruction (registered)
//   opcode       out  5        instr[INSTR_W-1 -: 5], to control decoder
//   instr_pc     out  ADDR_W   address of the issued instruction
//   busy         out  1        1 in FETCH/WAIT/ISSUE
//   halted       out  1        1 in HALT
//   issue_count  out  16       instructions accepted since reset, saturates at 16'hFFFF
// BEHAVIOUR
//   Reset (rst=1 at an edge, any state, overrides all other inputs):
//   - state=IDLE, pc=RESET_PC, and every output 0 except imem_addr=RESET_PC.
//   - An in-flight memory read is discarded.
//   FSM states IDLE, FETCH, WAIT, ISSUE, HALT:
//   - IDLE : start=1 -> FETCH; otherwise stay. All outputs idle.
//   - FETCH: imem_en=1, imem_addr=pc (combinational from state/pc reg); always -> WAIT.
//   - WAIT : at edge, instr<=imem_rdata, instr_pc<=pc; -> ISSUE.
//   - ISSUE: instr_valid=1; instr/opcode/instr_pc stable until handshake.
//       instr_ready=0          : stay, hold all values.
//       ready=1, opcode!=31    : pc<=pc+1; issue_count++; -> FETCH.
//       ready=1, opcode==31    : issue_count++; pc unchanged; -> HALT.
//   - HALT : halted=1, instr_valid=0, imem_en=0; start ignored; exits only by rst.
//   Rules:
//   - Handshake completes only on an edge with instr_valid & instr_ready both 1.
//   - instr_ready outside ISSUE is ignored.
//   - start outside IDLE is ignored; start and rst in the same cycle -> reset wins.
//   - Latency: start sampled at edge N -> imem_en in cycle N+1 -> instr_valid from cycle N+3.
//   - Accept at edge M -> next instr_valid from cycle M+3. Peak rate 1 instruction / 3 cycles.
//   - PC arithmetic is modulo 2^ADDR_W: pc=2^ADDR_W-1 wraps to 0 silently, no flag.
//   - issue_count saturates at 16'hFFFF and does not wrap.
//   - All outputs except imem_en/imem_addr are registered; no combinational path from instr_ready to any output.
// TESTING
//   1 Reset: rst=1 for 2 cycles in any state -> IDLE; all outputs 0; imem_addr=RESET_PC; count=0.
//   2 Straight-line: mem[0..2]={ADD,SUB,HLT}, start, ready=1 ->
//     - opcodes 0,1,31 issued with instr_pc 0,1,2;
//     - first valid 3 cycles after start;
//     - then halted=1, issue_count=3, busy=0.
//   3 Backpressure: ready=0 for 5 cycles during ISSUE -> instr/opcode/instr_pc stable, no imem_en;
//     ready=1 -> exactly one accept, pc+1.
//   4 Wrap: ADDR_W=4, RESET_PC=15, mem[15]=MOV, mem[0]=HLT -> instr_pc 15 then 0; halted=1.
//   5 Reset mid-operation:
//     - rst asserted in WAIT with mem data pending -> that data never appears as instr_valid;
//     - next start refetches from RESET_PC.
//   6 Halt sticky / start-ignore:
//     - start pulses in HALT and in ISSUE -> no state change;
//     - unimplemented opcode (e.g. 5'd7) is issued normally, not treated as halt.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch/issue sequencer for the GPP16 core. It walks a PC through a
// synchronous instruction memory and issues each instruction over a valid/ready handshake.
module instr_fetch_unit #(
  parameter int ADDR_W   = 8,
  parameter int INSTR_W  = 16,
  parameter int RESET_PC = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               imem_en,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [4:0]         opcode,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               busy,
  output logic               halted,
  output logic [15:0]        issue_count
);

  localparam logic [4:0]        OP_HLT  = 5'd31;
  localparam logic [ADDR_W-1:0] PC_INIT = ADDR_W'(RESET_PC);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_ISSUE = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   pc_reg;
  logic [INSTR_W-1:0]  instr_reg;
  logic [ADDR_W-1:0]   instr_pc_reg;
  logic [15:0]         count_reg;
  logic                accept;
  logic                is_halt;

  assign accept  = (state_reg == S_ISSUE) && instr_ready;
  assign is_halt = (instr_reg[INSTR_W-1 -: 5] == OP_HLT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (start) state_next = S_FETCH;
      S_FETCH: state_next = S_WAIT;
      S_WAIT:  state_next = S_ISSUE;
      S_ISSUE: if (accept) state_next = is_halt ? S_HALT : S_FETCH;
      S_HALT:  state_next = S_HALT;
      default: state_next = S_IDLE;
    endcase
  end

  // Read data is only captured in WAIT, so a reset there simply drops the pending word.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg       <= PC_INIT;
      instr_reg    <= '0;
      instr_pc_reg <= '0;
      count_reg    <= '0;
    end else begin
      if (state_reg == S_WAIT) begin
        instr_reg    <= imem_rdata;
        instr_pc_reg <= pc_reg;
      end
      if (accept) begin
        if (!is_halt) pc_reg <= pc_reg + ADDR_W'(1);
        if (count_reg != 16'hFFFF) count_reg <= count_reg + 16'd1;
      end
    end
  end

  always_comb begin
    imem_en     = 1'b0;
    instr_valid = 1'b0;
    busy        = 1'b0;
    halted      = 1'b0;
    case (state_reg)
      S_FETCH: begin
        imem_en = 1'b1;
        busy    = 1'b1;
      end
      S_WAIT:  busy = 1'b1;
      S_ISSUE: begin
        instr_valid = 1'b1;
        busy        = 1'b1;
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

  assign imem_addr   = pc_reg;
  assign instr       = instr_reg;
  assign opcode      = instr_reg[INSTR_W-1 -: 5];
  assign instr_pc    = instr_pc_reg;
  assign issue_count = count_reg;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: a memory model plus an expected-issue list derived from
// the program contents, with randomized backpressure and a small-PC wrap instance.
module tb_instr_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default instance (ADDR_W=8, RESET_PC=0)
  logic        rst = 1'b1, start = 1'b0, ready = 1'b0;
  logic        imem_en, instr_valid, busy, halted;
  logic [7:0]  imem_addr, instr_pc;
  logic [15:0] imem_rdata = '0, instr, issue_count;
  logic [4:0]  opcode;
  logic [15:0] mem [256];

  // Wrap instance (ADDR_W=4, RESET_PC=15)
  logic        rst_w = 1'b1, start_w = 1'b0, ready_w = 1'b0;
  logic        en_w, valid_w, busy_w, halted_w;
  logic [3:0]  addr_w, pc_w;
  logic [15:0] rdata_w = '0, instr_w, count_w;
  logic [4:0]  opcode_w;
  logic [15:0] mem_w [16];

  int tests_run = 0;
  int tests_failed = 0;

  instr_fetch_unit dut (
    .clk(clk), .rst(rst), .start(start), .imem_en(imem_en), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .instr_valid(instr_valid), .instr_ready(ready),
    .instr(instr), .opcode(opcode), .instr_pc(instr_pc), .busy(busy),
    .halted(halted), .issue_count(issue_count)
  );

  instr_fetch_unit #(.ADDR_W(4), .INSTR_W(16), .RESET_PC(15)) dut_w (
    .clk(clk), .rst(rst_w), .start(start_w), .imem_en(en_w), .imem_addr(addr_w),
    .imem_rdata(rdata_w), .instr_valid(valid_w), .instr_ready(ready_w),
    .instr(instr_w), .opcode(opcode_w), .instr_pc(pc_w), .busy(busy_w),
    .halted(halted_w), .issue_count(count_w)
  );

  always @(posedge clk) if (imem_en) imem_rdata <= mem[imem_addr];
  always @(posedge clk) if (en_w) rdata_w <= mem_w[addr_w];

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  function automatic logic [15:0] mk(input logic [4:0] op);
    return {op, 11'($urandom)};
  endfunction

  // Start the program at PC 0 and check every issue against the walk of mem.
  task automatic run_and_check(input string name, input int max_cycles, input int ready_pct);
    logic [7:0]  exp_pc [$];
    logic [15:0] exp_ins [$];
    logic [7:0]  p;
    logic [15:0] held;
    int idx, gap, cyc;
    bit prev_valid, done;
    p = 8'd0;
    for (int k = 0; k < 256; k++) begin
      exp_pc.push_back(p);
      exp_ins.push_back(mem[p]);
      if (mem[p][15:11] == 5'd31) break;
      p = p + 8'd1;
    end
    idx = 0; gap = 0; cyc = 0; prev_valid = 0; done = 0; held = '0;
    start = 1'b1;
    while (!done && cyc < max_cycles) begin
      tick();
      cyc++; gap++;
      start = 1'b0;
      if (instr_valid && !prev_valid) begin
        tests_run++;
        if (gap !== 3) begin
          tests_failed++;
          $display("FAIL %s latency: got %0d cycles, expected 3", name, gap);
        end
      end
      if (instr_valid && prev_valid) begin
        tests_run++;
        if (instr !== held || imem_en !== 1'b0) begin
          tests_failed++;
          $display("FAIL %s hold: instr %h (expected %h) imem_en %b (expected 0)", name, instr, held, imem_en);
        end
      end
      if (instr_valid) begin
        ready = ($urandom_range(99) < ready_pct);
        held = instr;
        if (ready) begin
          tests_run++;
          if (idx >= exp_pc.size()) begin
            tests_failed++;
            $display("FAIL %s extra issue: pc %h instr %h, expected none", name, instr_pc, instr);
          end else if (instr !== exp_ins[idx] || instr_pc !== exp_pc[idx] ||
                       opcode !== exp_ins[idx][15:11]) begin
            tests_failed++;
            $display("FAIL %s issue %0d: pc %h instr %h op %0d, expected pc %h instr %h",
                     name, idx, instr_pc, instr, opcode, exp_pc[idx], exp_ins[idx]);
          end
          $display("[TB] %s accept pc=%h instr=%h op=%0d", name, instr_pc, instr, opcode);
          idx++;
          gap = 0;
        end
      end else begin
        ready = 1'($urandom_range(1));
      end
      prev_valid = instr_valid && !ready;
      if (halted) done = 1;
    end
    ready = 1'b0;
    tests_run++;
    if (!done || idx != exp_pc.size() || issue_count !== 16'(exp_pc.size()) ||
        busy !== 1'b0 || instr_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s end: halted %b issued %0d count %0d busy %b, expected halted 1 issued/count %0d busy 0",
               name, halted, idx, issue_count, busy, exp_pc.size());
    end
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++;
    if ({instr_valid, imem_en, busy, halted, instr, instr_pc, issue_count, imem_addr} !== '0) begin
      tests_failed++;
      $display("FAIL reset_idle: v%b en%b busy%b halt%b instr %h pc %h cnt %0d addr %h, expected all 0",
               instr_valid, imem_en, busy, halted, instr, instr_pc, issue_count, imem_addr);
    end
    // Reset while WAIT holds pending read data.
    mem[0] = mk(5'd4); mem[1] = mk(5'd31);
    start = 1'b1; tick(); start = 1'b0; tick();
    tests_run++;
    if (busy !== 1'b1 || imem_en !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_setup: busy %b imem_en %b, expected 1 0", busy, imem_en);
    end
    rst = 1'b1; start = 1'b1; tick(); tick(); rst = 1'b0; start = 1'b0;
    tests_run++;
    if ({instr_valid, imem_en, busy, halted, instr, instr_pc, issue_count, imem_addr} !== '0) begin
      tests_failed++;
      $display("FAIL reset_mid: v%b en%b busy%b instr %h cnt %0d addr %h, expected all 0",
               instr_valid, imem_en, busy, instr, issue_count, imem_addr);
    end
    begin
      bit seen = 0;
      for (int i = 0; i < 6; i++) begin
        tick();
        if (instr_valid || busy) seen = 1;
      end
      tests_run++;
      if (seen) begin
        tests_failed++;
        $display("FAIL reset_discard: valid/busy seen 1 after reset, expected 0");
      end
    end
    run_and_check("refetch", 40, 100);
  endtask

  task automatic test_straight_line();
    do_reset();
    mem[0] = mk(5'd0); mem[1] = mk(5'd1); mem[2] = mk(5'd31);
    run_and_check("straight", 40, 100);
  endtask

  task automatic test_backpressure();
    logic [15:0] v;
    do_reset();
    mem[0] = mk(5'd7); mem[1] = mk(5'd31);
    start = 1'b1; tick(); start = 1'b0; tick(); tick();
    v = instr;
    tests_run++;
    if (instr_valid !== 1'b1 || v !== mem[0]) begin
      tests_failed++;
      $display("FAIL bp_first: valid %b instr %h, expected 1 %h", instr_valid, v, mem[0]);
    end
    for (int i = 0; i < 5; i++) begin
      start = (i == 2);
      tick();
      tests_run++;
      if (instr_valid !== 1'b1 || instr !== v || instr_pc !== 8'd0 || opcode !== 5'd7 ||
          imem_en !== 1'b0 || issue_count !== 16'd0) begin
        tests_failed++;
        $display("FAIL bp_hold%0d: v%b instr %h pc %h en %b cnt %0d, expected 1 %h 00 0 0",
                 i, instr_valid, instr, instr_pc, imem_en, issue_count, v);
      end
    end
    start = 1'b0; ready = 1'b1; tick(); ready = 1'b0;
    $display("[TB] bp accept pc=00 instr=%h", v);
    tests_run++;
    if (instr_valid !== 1'b0 || imem_en !== 1'b1 || imem_addr !== 8'd1 || issue_count !== 16'd1 ||
        halted !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_accept: v%b en%b addr %h cnt %0d halt %b, expected 0 1 01 1 0",
               instr_valid, imem_en, imem_addr, issue_count, halted);
    end
    tick(); tick();
    tests_run++;
    if (instr_valid !== 1'b1 || instr_pc !== 8'd1 || instr !== mem[1]) begin
      tests_failed++;
      $display("FAIL bp_second: v%b pc %h instr %h, expected 1 01 %h", instr_valid, instr_pc, instr, mem[1]);
    end
    ready = 1'b1; tick(); ready = 1'b0;
    $display("[TB] bp accept pc=01 instr=%h", mem[1]);
  endtask

  task automatic test_halt_sticky();
    for (int i = 0; i < 6; i++) begin
      start = i[0]; ready = i[1];
      tick();
      tests_run++;
      if (halted !== 1'b1 || busy !== 1'b0 || imem_en !== 1'b0 || instr_valid !== 1'b0 ||
          issue_count !== 16'd2 || imem_addr !== 8'd1) begin
        tests_failed++;
        $display("FAIL halt_sticky%0d: halt %b busy %b en %b v %b cnt %0d addr %h, expected 1 0 0 0 2 01",
                 i, halted, busy, imem_en, instr_valid, issue_count, imem_addr);
      end
    end
    start = 1'b0; ready = 1'b0;
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      int len;
      do_reset();
      len = $urandom_range(20, 2);
      for (int a = 0; a < 256; a++) mem[a] = 16'($urandom);
      for (int a = 0; a < len - 1; a++) if (mem[a][15:11] == 5'd31) mem[a][15:11] = 5'd7;
      mem[len-1][15:11] = 5'd31;
      run_and_check($sformatf("rand%0d", it), 3000, $urandom_range(100, 30));
    end
  endtask

  task automatic test_wrap();
    logic [3:0] exp_pc [2];
    int idx, cyc;
    exp_pc[0] = 4'd15; exp_pc[1] = 4'd0;
    for (int a = 0; a < 16; a++) mem_w[a] = mk(5'd2);
    mem_w[15] = mk(5'd3); mem_w[0] = mk(5'd31);
    rst_w = 1'b1; tick(); tick(); rst_w = 1'b0;
    tests_run++;
    if (addr_w !== 4'd15 || valid_w !== 1'b0 || count_w !== 16'd0) begin
      tests_failed++;
      $display("FAIL wrap_reset: addr %h valid %b cnt %0d, expected f 0 0", addr_w, valid_w, count_w);
    end
    ready_w = 1'b1; start_w = 1'b1;
    idx = 0; cyc = 0;
    while (!halted_w && cyc < 30) begin
      tick(); start_w = 1'b0; cyc++;
      if (valid_w) begin
        tests_run++;
        if (idx > 1 || pc_w !== exp_pc[idx[0]] || instr_w !== mem_w[exp_pc[idx[0]]]) begin
          tests_failed++;
          $display("FAIL wrap_issue%0d: pc %h instr %h, expected pc %h", idx, pc_w, instr_w, exp_pc[idx[0]]);
        end
        $display("[TB] wrap accept pc=%h instr=%h", pc_w, instr_w);
        idx++;
      end
    end
    ready_w = 1'b0;
    tests_run++;
    if (halted_w !== 1'b1 || idx != 2 || count_w !== 16'd2) begin
      tests_failed++;
      $display("FAIL wrap_end: halted %b issued %0d cnt %0d, expected 1 2 2", halted_w, idx, count_w);
    end
  endtask

  initial begin
    for (int a = 0; a < 256; a++) mem[a] = '0;
    for (int a = 0; a < 16; a++) mem_w[a] = '0;
    test_reset();
    test_straight_line();
    test_backpressure();
    test_halt_sticky();
    test_random();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
